// File: rtl/vector_element_sequencer_if.sv
// Issue, configuration, element-descriptor and write-back signals of the
// vector element sequencer. The sequencer uses the slave side.
interface vector_element_sequencer_if #(
  parameter int VLEN = 128
) ();
  logic            op_valid;
  logic            op_ready;
  logic [4:0]      op_vd;
  logic [4:0]      op_vs1;
  logic [4:0]      op_vs2;
  logic            op_vm;
  logic            op_kill;
  logic [31:0]     cfg_vl;
  logic [31:0]     cfg_vstart;
  logic            cfg_vill;
  logic [2:0]      cfg_vsew;
  logic [2:0]      cfg_vlmul;
  logic [VLEN-1:0] cfg_masks;
  logic            elem_valid;
  logic            elem_ready;
  logic [31:0]     elem_idx;
  logic [4:0]      elem_vd_reg;
  logic [4:0]      elem_vs1_reg;
  logic [4:0]      elem_vs2_reg;
  logic [31:0]     elem_bit_off;
  logic [31:0]     elem_width;
  logic            elem_active;
  logic            vstart_we;
  logic [31:0]     new_vstart;
  logic            done;
  logic            trap;

  modport master (
    output op_valid, op_vd, op_vs1, op_vs2, op_vm, op_kill,
    output cfg_vl, cfg_vstart, cfg_vill, cfg_vsew, cfg_vlmul, cfg_masks,
    output elem_ready,
    input  op_ready, elem_valid, elem_idx, elem_vd_reg, elem_vs1_reg, elem_vs2_reg,
    input  elem_bit_off, elem_width, elem_active, vstart_we, new_vstart, done, trap
  );

  modport slave (
    input  op_valid, op_vd, op_vs1, op_vs2, op_vm, op_kill,
    input  cfg_vl, cfg_vstart, cfg_vill, cfg_vsew, cfg_vlmul, cfg_masks,
    input  elem_ready,
    output op_ready, elem_valid, elem_idx, elem_vd_reg, elem_vs1_reg, elem_vs2_reg,
    output elem_bit_off, elem_width, elem_active, vstart_we, new_vstart, done, trap
  );
endinterface

// File: rtl/vector_element_sequencer.sv
// Walks the elements of one vector op from vstart to min(vl, VLMAX), emitting a
// registered per-element descriptor, then writes vstart back on finish or kill.
module vector_element_sequencer #(
  parameter int VLEN = 128
) (
  input logic                       SYS_clk,
  input logic                       SYS_reset_n,
  vector_element_sequencer_if.slave bus
);
  localparam int LOG2_VLEN = $clog2(VLEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2,
    S_TRAP = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [31:0]     r_idx;
  logic [31:0]     r_end;
  logic [2:0]      r_sew_log;
  logic [3:0]      r_epr_log;
  logic [4:0]      r_vd;
  logic [4:0]      r_vs1;
  logic [4:0]      r_vs2;
  logic            r_vm;
  logic [VLEN-1:0] r_masks;
  logic [4:0]      r_vd_reg;
  logic [4:0]      r_vs1_reg;
  logic [4:0]      r_vs2_reg;
  logic [31:0]     r_bit_off;
  logic [31:0]     r_width;
  logic            r_active;
  logic            r_killed;
  logic [31:0]     r_new_vstart;

  logic            w_illegal;
  logic [2:0]      w_sew_log;
  logic [1:0]      w_g_log;
  logic [3:0]      w_epr_log;
  logic [31:0]     w_vlmax;
  logic [31:0]     w_end;
  logic            w_accept;
  logic            w_hs;
  logic            w_last;
  logic            w_load;
  logic            w_fin_kill;
  logic [31:0]     w_fin_vstart;

  logic [31:0]     w_d_idx;
  logic [2:0]      w_d_sew;
  logic [3:0]      w_d_epr;
  logic [4:0]      w_d_vd;
  logic [4:0]      w_d_vs1;
  logic [4:0]      w_d_vs2;
  logic            w_d_vm;
  logic            w_d_mbit;
  logic [4:0]      w_d_grp;

  // vtype decode; SEW and group size are kept as log2 so all scaling is shifts
  always_comb begin
    w_illegal = bus.cfg_vill;
    w_sew_log = 3'd3;
    w_g_log   = 2'd0;
    case (bus.cfg_vsew)
      3'b000:  w_sew_log = 3'd3;
      3'b001:  w_sew_log = 3'd4;
      3'b010:  w_sew_log = 3'd5;
      default: w_illegal = 1'b1;
    endcase
    case (bus.cfg_vlmul)
      3'b000:  w_g_log = 2'd0;
      3'b001:  w_g_log = 2'd1;
      3'b010:  w_g_log = 2'd2;
      3'b011:  w_g_log = 2'd3;
      3'b100:  w_illegal = 1'b1;
      default: w_g_log = 2'd0;
    endcase
  end

  assign w_epr_log = 4'(LOG2_VLEN) - {1'b0, w_sew_log};
  assign w_vlmax   = 32'd1 << (w_epr_log + {2'b00, w_g_log});
  assign w_end     = (bus.cfg_vl < w_vlmax) ? bus.cfg_vl : w_vlmax;

  assign w_accept  = bus.op_valid && (r_state == S_IDLE);
  assign w_hs      = (r_state == S_RUN) && bus.elem_ready;
  assign w_last    = (r_idx + 32'd1) == r_end;

  always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) r_state <= S_IDLE;
    else              r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_load       = 1'b0;
    w_fin_kill   = 1'b0;
    w_fin_vstart = 32'd0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_illegal)                    w_state_nxt = S_TRAP;
          else if (bus.cfg_vstart >= w_end) w_state_nxt = S_FIN;
          else begin
            w_state_nxt = S_RUN;
            w_load      = 1'b1;
          end
        end
      end
      S_RUN: begin
        // retiring the last element wins over a kill in the same cycle
        if (w_hs && w_last) begin
          w_state_nxt = S_FIN;
        end else if (bus.op_kill) begin
          w_state_nxt  = S_FIN;
          w_fin_kill   = 1'b1;
          w_fin_vstart = w_hs ? (r_idx + 32'd1) : r_idx;
        end else if (w_hs) begin
          w_load = 1'b1;
        end
      end
      S_FIN:   w_state_nxt = S_IDLE;
      S_TRAP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next descriptor source: issue-time values on accept, latched op state after
  always_comb begin
    if (r_state == S_IDLE) begin
      w_d_idx  = bus.cfg_vstart;
      w_d_sew  = w_sew_log;
      w_d_epr  = w_epr_log;
      w_d_vd   = bus.op_vd;
      w_d_vs1  = bus.op_vs1;
      w_d_vs2  = bus.op_vs2;
      w_d_vm   = bus.op_vm;
      w_d_mbit = bus.cfg_masks[bus.cfg_vstart[LOG2_VLEN-1:0]];
    end else begin
      w_d_idx  = r_idx + 32'd1;
      w_d_sew  = r_sew_log;
      w_d_epr  = r_epr_log;
      w_d_vd   = r_vd;
      w_d_vs1  = r_vs1;
      w_d_vs2  = r_vs2;
      w_d_vm   = r_vm;
      w_d_mbit = r_masks[w_d_idx[LOG2_VLEN-1:0]];
    end
  end

  assign w_d_grp = 5'(w_d_idx >> w_d_epr);

  always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) begin
      r_idx        <= '0;
      r_end        <= '0;
      r_sew_log    <= '0;
      r_epr_log    <= '0;
      r_vd         <= '0;
      r_vs1        <= '0;
      r_vs2        <= '0;
      r_vm         <= 1'b0;
      r_masks      <= '0;
      r_vd_reg     <= '0;
      r_vs1_reg    <= '0;
      r_vs2_reg    <= '0;
      r_bit_off    <= '0;
      r_width      <= '0;
      r_active     <= 1'b0;
      r_killed     <= 1'b0;
      r_new_vstart <= '0;
    end else begin
      r_killed     <= w_fin_kill;
      r_new_vstart <= w_fin_vstart;
      if (w_accept) begin
        r_end     <= w_end;
        r_sew_log <= w_sew_log;
        r_epr_log <= w_epr_log;
        r_vd      <= bus.op_vd;
        r_vs1     <= bus.op_vs1;
        r_vs2     <= bus.op_vs2;
        r_vm      <= bus.op_vm;
        r_masks   <= bus.cfg_masks;
      end
      if (w_load) begin
        r_idx     <= w_d_idx;
        r_vd_reg  <= w_d_vd + w_d_grp;
        r_vs1_reg <= w_d_vs1 + w_d_grp;
        r_vs2_reg <= w_d_vs2 + w_d_grp;
        r_bit_off <= (w_d_idx & ((32'd1 << w_d_epr) - 32'd1)) << w_d_sew;
        r_width   <= 32'd1 << w_d_sew;
        r_active  <= w_d_vm | w_d_mbit;
      end
    end
  end

  assign bus.op_ready     = (r_state == S_IDLE);
  assign bus.elem_valid   = (r_state == S_RUN);
  assign bus.elem_idx     = r_idx;
  assign bus.elem_vd_reg  = r_vd_reg;
  assign bus.elem_vs1_reg = r_vs1_reg;
  assign bus.elem_vs2_reg = r_vs2_reg;
  assign bus.elem_bit_off = r_bit_off;
  assign bus.elem_width   = r_width;
  assign bus.elem_active  = r_active;
  assign bus.vstart_we    = (r_state == S_FIN);
  assign bus.new_vstart   = r_new_vstart;
  assign bus.done         = (r_state == S_FIN) && !r_killed;
  assign bus.trap         = (r_state == S_TRAP);
endmodule

// File: tb/tb_vector_element_sequencer.sv
// Drives directed and random ops into the sequencer and checks every cycle
// against an arithmetic model of the element walk.
module tb_vector_element_sequencer;
  localparam int VLEN = 128;

  logic SYS_clk = 1'b0;
  logic SYS_reset_n = 1'b0;
  always #5 SYS_clk = ~SYS_clk;

  vector_element_sequencer_if #(.VLEN(VLEN)) bif ();
  vector_element_sequencer #(.VLEN(VLEN)) dut (
    .SYS_clk     (SYS_clk),
    .SYS_reset_n (SYS_reset_n),
    .bus         (bif)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  function automatic logic [VLEN-1:0] rnd_mask();
    logic [VLEN-1:0] m;
    for (int i = 0; i < VLEN / 32; i++) m[i*32 +: 32] = $urandom;
    return m;
  endfunction

  task automatic scramble_inputs();
    bif.op_vd      = 5'($urandom);
    bif.op_vs1     = 5'($urandom);
    bif.op_vs2     = 5'($urandom);
    bif.op_vm      = 1'($urandom);
    bif.cfg_vl     = $urandom;
    bif.cfg_vstart = $urandom;
    bif.cfg_vill   = 1'($urandom);
    bif.cfg_vsew   = 3'($urandom);
    bif.cfg_vlmul  = 3'($urandom);
    bif.cfg_masks  = rnd_mask();
  endtask

  task automatic run_op(input logic [4:0] vd, input logic [4:0] vs1, input logic [4:0] vs2,
                        input logic vm, input int vl, input int vstart, input logic vill,
                        input logic [2:0] vsew, input logic [2:0] vlmul,
                        input logic [VLEN-1:0] masks, input int rdy_pct,
                        input int stall_at, input int kill_at, input logic kill_rdy);
    int  sew, g, epr, vlmax, endi, idx, grp, nvs, n_el, stall_left;
    bit  legal, m_run, m_fin, m_trap, m_done, stalled, rdy, kill, finished;
    legal = !vill && (vsew <= 3'd2) && (vlmul != 3'd4);
    sew   = 8 << ((vsew > 3'd2) ? 0 : int'(vsew));
    g     = (vlmul <= 3'd3) ? (1 << vlmul) : 1;
    epr   = VLEN / sew;
    vlmax = epr * g;
    endi  = (vl < vlmax) ? vl : vlmax;

    @(negedge SYS_clk);
    chk("op_ready_idle", 32'(bif.op_ready), 32'd1);
    bif.op_valid   = 1'b1;
    bif.op_vd      = vd;
    bif.op_vs1     = vs1;
    bif.op_vs2     = vs2;
    bif.op_vm      = vm;
    bif.cfg_vl     = vl;
    bif.cfg_vstart = vstart;
    bif.cfg_vill   = vill;
    bif.cfg_vsew   = vsew;
    bif.cfg_vlmul  = vlmul;
    bif.cfg_masks  = masks;
    bif.op_kill    = 1'($urandom);
    bif.elem_ready = 1'($urandom);
    @(posedge SYS_clk);
    @(negedge SYS_clk);
    bif.op_valid = 1'b0;
    bif.op_kill  = 1'b0;
    scramble_inputs();

    m_run = 0; m_fin = 0; m_trap = 0; m_done = 0; nvs = 0;
    idx = vstart; n_el = 0; stalled = 0; stall_left = 0; finished = 0;
    if (!legal)             m_trap = 1;
    else if (vstart >= endi) begin m_fin = 1; m_done = 1; end
    else                    m_run = 1;

    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      chk("elem_valid", 32'(bif.elem_valid), 32'(m_run));
      chk("trap", 32'(bif.trap), 32'(m_trap));
      chk("vstart_we", 32'(bif.vstart_we), 32'(m_fin));
      chk("done", 32'(bif.done), 32'(m_fin && m_done));
      chk("op_ready_busy", 32'(bif.op_ready), 32'd0);
      if (m_fin) chk("new_vstart", bif.new_vstart, 32'(nvs));
      if (m_run) begin
        grp = idx / epr;
        chk("elem_idx", bif.elem_idx, 32'(idx));
        chk("elem_vd_reg", 32'(bif.elem_vd_reg), 32'((int'(vd) + grp) % 32));
        chk("elem_vs1_reg", 32'(bif.elem_vs1_reg), 32'((int'(vs1) + grp) % 32));
        chk("elem_vs2_reg", 32'(bif.elem_vs2_reg), 32'((int'(vs2) + grp) % 32));
        chk("elem_bit_off", bif.elem_bit_off, 32'((idx % epr) * sew));
        chk("elem_width", bif.elem_width, 32'(sew));
        chk("elem_active", 32'(bif.elem_active), 32'(vm | masks[idx]));
      end
      if (m_fin || m_trap) begin
        finished = 1;
      end else begin
        if (idx == stall_at && !stalled) begin stalled = 1; stall_left = 3; end
        if (stall_left > 0) begin rdy = 0; stall_left--; end
        else rdy = ($urandom_range(1, 100) <= rdy_pct);
        kill = (idx == kill_at);
        if (kill) rdy = kill_rdy;
        bif.elem_ready = rdy;
        bif.op_kill    = kill;
        if (bif.elem_valid && rdy) n_el++;
        if (rdy && idx + 1 == endi) begin
          m_run = 0; m_fin = 1; m_done = 1; nvs = 0;
        end else if (kill) begin
          m_run = 0; m_fin = 1; m_done = 0; nvs = rdy ? idx + 1 : idx;
        end else if (rdy) begin
          idx++;
        end
        @(posedge SYS_clk);
        @(negedge SYS_clk);
        bif.op_kill = 1'b0;
      end
    end
    if (!finished) chk("timeout", 32'd0, 32'd1);
    if (m_trap) chk("trap_elems", 32'(n_el), 32'd0);
    else if (m_done) chk("elem_count", 32'(n_el), 32'((vstart < endi) ? endi - vstart : 0));
    else chk("kill_elem_count", 32'(n_el), 32'(nvs - vstart));
    // kill presented during FIN/TRAP must have no effect
    bif.op_kill = 1'($urandom);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_op_ready"}, 32'(bif.op_ready), 32'd1);
    chk({tag, "_elem_valid"}, 32'(bif.elem_valid), 32'd0);
    chk({tag, "_vstart_we"}, 32'(bif.vstart_we), 32'd0);
    chk({tag, "_done"}, 32'(bif.done), 32'd0);
    chk({tag, "_trap"}, 32'(bif.trap), 32'd0);
    chk({tag, "_new_vstart"}, bif.new_vstart, 32'd0);
    chk({tag, "_elem_idx"}, bif.elem_idx, 32'd0);
    chk({tag, "_elem_width"}, bif.elem_width, 32'd0);
    chk({tag, "_elem_vd_reg"}, 32'(bif.elem_vd_reg), 32'd0);
  endtask

  initial begin
    logic [VLEN-1:0] m;
    bif.op_valid   = 1'b0;
    bif.op_kill    = 1'b0;
    bif.elem_ready = 1'b0;
    scramble_inputs();
    bif.op_valid   = 1'b0;
    #12;
    chk_reset_outputs("rst");
    @(negedge SYS_clk);
    SYS_reset_n = 1'b1;

    m = '0;
    run_op(5'd8, 5'd1, 5'd2, 1'b1, 6, 0, 1'b0, 3'b010, 3'b001, m, 100, -1, -1, 1'b0);
    m = '0; m[3:0] = 4'b1010;
    run_op(5'd3, 5'd4, 5'd5, 1'b0, 4, 0, 1'b0, 3'b000, 3'b000, m, 100, -1, -1, 1'b0);
    m = rnd_mask();
    run_op(5'd8, 5'd10, 5'd12, 1'b0, 6, 0, 1'b0, 3'b010, 3'b001, m, 100, 2, -1, 1'b0);
    run_op(5'd8, 5'd10, 5'd12, 1'b1, 6, 0, 1'b0, 3'b010, 3'b001, m, 100, -1, 3, 1'b0);
    run_op(5'd8, 5'd10, 5'd12, 1'b1, 6, 3, 1'b0, 3'b010, 3'b001, m, 100, -1, -1, 1'b0);
    run_op(5'd8, 5'd10, 5'd12, 1'b1, 6, 0, 1'b0, 3'b010, 3'b001, m, 100, -1, 2, 1'b1);
    run_op(5'd8, 5'd10, 5'd12, 1'b1, 6, 0, 1'b0, 3'b010, 3'b001, m, 100, -1, 5, 1'b1);
    run_op(5'd1, 5'd2, 5'd3, 1'b1, 6, 0, 1'b1, 3'b010, 3'b001, m, 100, -1, -1, 1'b0);
    run_op(5'd1, 5'd2, 5'd3, 1'b1, 6, 0, 1'b0, 3'b010, 3'b100, m, 100, -1, -1, 1'b0);
    run_op(5'd1, 5'd2, 5'd3, 1'b1, 6, 0, 1'b0, 3'b011, 3'b000, m, 100, -1, -1, 1'b0);
    run_op(5'd1, 5'd2, 5'd3, 1'b1, 5, 5, 1'b0, 3'b010, 3'b000, m, 100, -1, -1, 1'b0);
    run_op(5'd1, 5'd2, 5'd3, 1'b1, 100, 0, 1'b0, 3'b010, 3'b000, m, 100, -1, -1, 1'b0);
    run_op(5'd30, 5'd29, 5'd31, 1'b0, 16, 0, 1'b0, 3'b010, 3'b010, m, 100, -1, -1, 1'b0);
    run_op(5'd7, 5'd9, 5'd11, 1'b0, 200, 0, 1'b0, 3'b000, 3'b111, m, 70, -1, -1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      int vl, vs, ka;
      vl = $urandom_range(0, 140);
      vs = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 150) : $urandom_range(0, 12);
      ka = ($urandom_range(0, 3) == 0) ? vs + $urandom_range(0, 10) : -1;
      run_op(5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), vl, vs,
             ($urandom_range(0, 15) == 0), 3'($urandom_range(0, 3)), 3'($urandom),
             rnd_mask(), $urandom_range(40, 100), -1, ka, 1'($urandom));
    end

    // reset in the middle of a run drops the op without a vstart write
    @(negedge SYS_clk);
    bif.op_valid = 1'b1; bif.op_vd = 5'd8; bif.op_vm = 1'b1;
    bif.cfg_vl = 32'd8; bif.cfg_vstart = 32'd0; bif.cfg_vill = 1'b0;
    bif.cfg_vsew = 3'b010; bif.cfg_vlmul = 3'b001; bif.elem_ready = 1'b1; bif.op_kill = 1'b0;
    @(posedge SYS_clk);
    @(negedge SYS_clk);
    bif.op_valid = 1'b0;
    chk("midrun_elem_valid", 32'(bif.elem_valid), 32'd1);
    @(posedge SYS_clk);
    @(negedge SYS_clk);
    SYS_reset_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(negedge SYS_clk);
    SYS_reset_n = 1'b1;
    @(negedge SYS_clk);
    chk("postrst_vstart_we", 32'(bif.vstart_we), 32'd0);
    chk("postrst_op_ready", 32'(bif.op_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
